// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared dmem.
// The arbiter takes the slave modport; the requester/memory side takes master.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // Port 0: processor load/store
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;

  // Port 1: loader/debug DMA
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;

  // Shared read data and dmem side
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;

  // Aging state, visible for checkers
  logic              boost;
  logic [3:0]        wait_cnt;

  // Handshake: a requester raises req with we/addr/wdata and holds all of them
  // stable until it sees gnt high in the same cycle; that cycle consumes the
  // request. Reads return rvalid exactly RD_LAT cycles after the grant edge.
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  q_dmem,
    output gnt0, rvalid0, gnt1, rvalid1,
    output rdata, address_dmem, data, wren,
    output boost, wait_cnt
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output q_dmem,
    input  gnt0, rvalid0, gnt1, rvalid1,
    input  rdata, address_dmem, data, wren,
    input  boost, wait_cnt
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for a single-port synchronous dmem: one access per clock,
// aging boost for port 1, and an in-order read-tag pipeline for return routing.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic               clock,
  input  logic               reset,
  dmem_port_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  logic [3:0] wait_cnt;
  tag_t       tag_q [RD_LAT];
  tag_t       tag_tail;
  logic       boost_c;
  logic       g0;
  logic       g1;
  logic       rd_grant;

  // Grants are gated by reset so nothing reaches dmem while reset is high.
  always_comb begin
    boost_c  = (wait_cnt == MAX_CNT);
    g1       = !reset && bus.req1 && (boost_c || !bus.req0);
    g0       = !reset && bus.req0 && !g1;
    rd_grant = (g0 && !bus.we0) || (g1 && !bus.we1);
    tag_tail = tag_q[RD_LAT-1];
  end

  always_comb begin
    bus.gnt0         = g0;
    bus.gnt1         = g1;
    bus.boost        = !reset && boost_c;
    bus.wait_cnt     = wait_cnt;
    bus.address_dmem = '0;
    bus.data         = '0;
    bus.wren         = 1'b0;
    if (g1) begin
      bus.address_dmem = bus.addr1;
      bus.data         = bus.wdata1;
      bus.wren         = bus.we1;
    end else if (g0) begin
      bus.address_dmem = bus.addr0;
      bus.data         = bus.wdata0;
      bus.wren         = bus.we0;
    end
  end

  // The tail tag lines up with the cycle dmem presents the matching q.
  always_comb begin
    bus.rdata   = bus.q_dmem;
    bus.rvalid0 = !reset && tag_tail.valid && !tag_tail.id;
    bus.rvalid1 = !reset && tag_tail.valid &&  tag_tail.id;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= 4'd0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      if (!bus.req1 || g1) begin
        wait_cnt <= 4'd0;
      end else if (wait_cnt != MAX_CNT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      tag_q[0].valid <= rd_grant;
      tag_q[0].id    <= g1;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: grant/drive checks per cycle, read
// returns checked by a scoreboard fed at grant time and drained by a monitor.
module tb_dmem_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_port_arbiter_if #(.ADDR_W(12), .DATA_W(32)) u_if ();
  dmem_port_arbiter_if #(.ADDR_W(12), .DATA_W(32)) u_if2 ();

  dmem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(1), .MAX_WAIT(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.slave)
  );

  dmem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(1), .MAX_WAIT(0)) dut_fixed (
    .clock (clock),
    .reset (reset),
    .bus   (u_if2.slave)
  );

  // Behavioural synchronous RAM, one cycle read latency, read-before-write.
  logic [31:0] mem [0:4095];
  logic [31:0] q_r;
  always @(posedge clock) begin
    if (u_if.wren) mem[u_if.address_dmem] <= u_if.data;
    q_r <= mem[u_if.address_dmem];
  end
  assign u_if.q_dmem  = q_r;
  assign u_if2.q_dmem = 32'h0;

  int tests  = 0;
  int failed = 0;
  logic [32:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set0(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d);
    u_if.req0 = r; u_if.we0 = w; u_if.addr0 = a; u_if.wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d);
    u_if.req1 = r; u_if.we1 = w; u_if.addr1 = a; u_if.wdata1 = d;
  endtask

  // One cycle: check grant and dmem drive, queue the read return if expected.
  task automatic step(input logic eg0, input logic eg1, input logic eb,
                      input logic [31:0] erd, input bit push);
    logic [11:0] ea;
    logic [31:0] ed;
    logic        ew;
    ea = eg1 ? u_if.addr1  : (eg0 ? u_if.addr0  : 12'h0);
    ed = eg1 ? u_if.wdata1 : (eg0 ? u_if.wdata0 : 32'h0);
    ew = (eg1 && u_if.we1) || (eg0 && u_if.we0);
    @(negedge clock);
    chk("gnt0", u_if.gnt0, eg0);
    chk("gnt1", u_if.gnt1, eg1);
    chk("boost", u_if.boost, eb);
    chk("wren", u_if.wren, ew);
    chk("address_dmem", u_if.address_dmem, ea);
    chk("data", u_if.data, ed);
    if (push && ((eg0 && !u_if.we0) || (eg1 && !u_if.we1)))
      exp_q.push_back({eg1, erd});
    @(posedge clock);
    #1;
  endtask

  // Monitor: every presented rvalid must match the oldest expected return.
  always @(negedge clock) begin
    logic [32:0] e;
    if (u_if.rvalid0 && u_if.rvalid1) begin
      tests++; failed++;
      $display("FAIL rvalid_both: got rvalid0=1 rvalid1=1 expected at most one at %0t", $time);
    end else if (u_if.rvalid0 || u_if.rvalid1) begin
      if (exp_q.size() == 0) begin
        tests++; failed++;
        $display("FAIL rvalid_unexpected: got rvalid0=%0b rvalid1=%0b expected none at %0t",
                 u_if.rvalid0, u_if.rvalid1, $time);
      end else begin
        e = exp_q.pop_front();
        chk("rvalid_id", {63'h0, u_if.rvalid1}, {63'h0, e[32]});
        chk("rdata", {32'h0, u_if.rdata}, {32'h0, e[31:0]});
      end
    end
  end

  initial begin
    set0(1'b1, 1'b0, 12'h0AB, 32'h0);
    set1(1'b1, 1'b1, 12'h0CD, 32'h1234);
    u_if2.req0 = 0; u_if2.we0 = 0; u_if2.addr0 = 0; u_if2.wdata0 = 0;
    u_if2.req1 = 0; u_if2.we1 = 0; u_if2.addr1 = 0; u_if2.wdata1 = 0;

    // Reset with requests pending: everything forced low
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    reset = 1'b0;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("wait_cnt_reset", u_if.wait_cnt, 0);

    // Port 0 store then load of the same word
    set0(1, 1, 12'h010, 32'hDEADBEEF);
    step(1, 0, 0, 0, 1);
    set0(1, 0, 12'h010, 32'h0);
    step(1, 0, 0, 32'hDEADBEEF, 1);

    // Port 1 alone: immediate grant, no aging
    set0(0, 0, 0, 0);
    set1(1, 1, 12'h001, 32'h11);
    step(0, 1, 0, 0, 1);
    set1(1, 1, 12'h002, 32'h22);
    step(0, 1, 0, 0, 1);
    chk("wait_cnt_p1_alone", u_if.wait_cnt, 0);

    // Alternating back-to-back reads, tags in order
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        set0(1, 0, 12'h001, 0); set1(0, 0, 0, 0);
        step(1, 0, 0, 32'h11, 1);
      end else begin
        set0(0, 0, 0, 0); set1(1, 0, 12'h002, 0);
        step(0, 1, 0, 32'h22, 1);
      end
    end

    // Both held: 3 grants to port 0, then boosted port 1
    set0(1, 0, 12'h010, 0);
    set1(1, 0, 12'h002, 0);
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 3) step(0, 1, 1, 32'h22, 1);
      else            step(1, 0, 0, 32'hDEADBEEF, 1);
    end
    chk("wait_cnt_after_boost", u_if.wait_cnt, 0);

    // Port 1 read then reset next cycle: the return is flushed
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    set1(1, 0, 12'h002, 0);
    step(0, 1, 0, 0, 0);
    reset = 1'b1;
    set0(1, 1, 12'h055, 32'hA5A5A5A5);
    set1(0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    reset = 1'b0;
    set0(0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Fixed priority instance: port 1 always wins
    u_if2.req0 = 1; u_if2.addr0 = 12'h003;
    u_if2.req1 = 1; u_if2.addr1 = 12'h004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("fixed_gnt1", u_if2.gnt1, 1);
      chk("fixed_gnt0", u_if2.gnt0, 0);
      chk("fixed_boost", u_if2.boost, 1);
      chk("fixed_addr", u_if2.address_dmem, 12'h004);
      @(posedge clock);
      #1;
    end
    u_if2.req0 = 0; u_if2.req1 = 0;

    repeat (3) step(0, 0, 0, 0, 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port synchronous data memory (12-bit word address, 32-bit data) between two requesters: port 0 (processor load/store) and port 1 (loader/debug DMA).
- Grants at most one access per clock.
- Aging counter keeps port 1 from starving.
- Tracks in-flight reads so the registered RAM output returns only to the port that issued the read.
- Sits between processor/loader and the dmem instance; dmem is clocked by the same clock.

Parameters:
- ADDR_W, 12, memory word-address width
- DATA_W, 32, data width
- RD_LAT, 1, cycles from a granted read to valid q_dmem (1..4)
- MAX_WAIT, 3, consecutive denied cycles of port 1 before port 1 is boosted above port 0 (0..15)

Ports:
- clock  in  1  single system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 access request
- we0  in  1  port 0 write enable (1=store, 0=load)
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 store data
- gnt0  out  1  port 0 granted this cycle
- rvalid0  out  1  port 0 read data valid
- req1, we1, addr1, wdata1, gnt1, rvalid1  same as port 0, for port 1
- rdata  out  DATA_W  read data, shared by both ports (equals q_dmem)
- address_dmem  out  ADDR_W  to dmem address
- data  out  DATA_W  to dmem write data
- wren  out  1  to dmem write enable
- q_dmem  in  DATA_W  from dmem read data
- boost  out  1  port 1 currently holds boosted priority

Behaviour:
- Reset (reset=1 at a rising edge):
  - wait_cnt=0; read-tag pipeline cleared.
  - While reset is high, gnt0, gnt1, wren, rvalid0, rvalid1 and boost are forced to 0.
  - address_dmem and data are 0.
- Arbitration is combinational within the cycle:
  - boost = (wait_cnt == MAX_WAIT).
  - If req1 && (boost || !req0): gnt1=1.
  - Else if req0: gnt0=1.
  - gnt0 and gnt1 are never both 1.
- Memory drive:
  - Winner's addr/wdata go to address_dmem/data; wren = winner's we.
  - With no grant: address_dmem=0, data=0, wren=0.
- Handshake:
  - A request is consumed in the cycle its gnt is 1.
  - A denied requester holds req, we, addr and wdata stable until granted.
  - The arbiter never queues requests.
- Aging counter (wait_cnt, 4 bits):
  - Increments on every edge where req1=1 and gnt1=0; saturates at MAX_WAIT.
  - Cleared to 0 on gnt1 or when req1=0.
  - MAX_WAIT=0 gives port 1 fixed priority.
- Read return:
  - A granted read (we=0) pushes {valid=1, id} into an RD_LAT-deep shift register; a write or idle cycle pushes valid=0.
  - At the tail: rvalid<id>=1 exactly RD_LAT cycles after the grant edge.
  - rdata = q_dmem unconditionally.
  - Writes never produce rvalid.
- Back-to-back reads from either or both ports are allowed every cycle; tags remain in order.
- Reset mid-read flushes all tags: no rvalid for reads granted before reset.
- Port 1 requesting while port 0 idle: granted immediately, no wait increment.

Test Plan:
- Reset then idle → gnt0=gnt1=wren=rvalid0=rvalid1=boost=0, address_dmem=0.
- req0 write addr=0x010 wdata=0xDEADBEEF, then req0 read addr=0x010 → gnt0 both cycles; wren=1 then 0; rvalid0=1 one cycle after read grant with rdata=0xDEADBEEF; rvalid1 stays 0.
- req0 and req1 held high continuously, MAX_WAIT=3 → gnt0 for 3 cycles, boost=1 and gnt1 on 4th, wait_cnt back to 0, pattern repeats 3:1.
- Alternating reads port0 addr 0x001 / port1 addr 0x002 every cycle (contents 0x11 / 0x22) → rvalid alternates, correctly tagged; rdata matches port's address.
- Read granted to port1, reset asserted next cycle → no rvalid1 afterwards; all outputs 0 during reset.
- MAX_WAIT=0 with both requesting → gnt1 every cycle, gnt0 never, boost=1.
